// File: rtl/hssl_pkg.sv
// Shared HSSL definitions: configuration key defaults, register-address field
// layout used by the register bank, and the packet container type.
package hssl_pkg;

  localparam logic [31:0] CFG_KEY_DEF  = 32'hffff_fe00;
  localparam logic [31:0] CFG_MASK_DEF = 32'hffff_ff00;

  // Register word address layout: section in [6:4], register number in [3:0].
  localparam int SEC_BITS    = 3;
  localparam int REG_BITS    = 4;
  localparam int PRX_SEC_LSB = 4;

  typedef struct packed {
    logic [31:0] key;
    logic [31:0] payload;
    logic        has_pld;
  } pkt_t;

  function automatic logic key_hit(
    input logic [31:0] key,
    input logic [31:0] ref_key,
    input logic [31:0] mask
  );
    return (key & mask) == (ref_key & mask);
  endfunction

endpackage

// File: rtl/pkt_fwd_reg.sv
// Single-entry valid/ready pipeline register. A new packet may be loaded in the
// same cycle the held one drains, so it sustains one packet per cycle.
module pkt_fwd_reg
  import hssl_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  pkt_t din,
  input  logic load,
  output logic free,
  output pkt_t dout,
  output logic vld,
  input  logic rdy
);

  pkt_t pkt_p1;
  logic vld_p1;

  assign free = !vld_p1 || rdy;

  // Stage p0 -> p1: load has priority over drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
      pkt_p1 <= '0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      pkt_p1 <= din;
    end else if (rdy) begin
      vld_p1 <= 1'b0;
    end
  end

  assign dout = pkt_p1;
  assign vld  = vld_p1;

endmodule

// File: rtl/hssl_cfg_pkt_rx.sv
// HSSL configuration packet receiver: turns key-matched packets into register
// writes and forwards every other packet, in order, to the input router.
module hssl_cfg_pkt_rx
  import hssl_pkg::*;
#(
  parameter logic [31:0] CFG_KEY   = CFG_KEY_DEF,
  parameter logic [31:0] CFG_MASK  = CFG_MASK_DEF,
  parameter int          ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          pkt_key_in,
  input  logic [31:0]          pkt_payload_in,
  input  logic                 pkt_has_pld_in,
  input  logic                 pkt_vld_in,
  output logic                 pkt_rdy_out,
  output logic [31:0]          fwd_key_out,
  output logic [31:0]          fwd_payload_out,
  output logic                 fwd_has_pld_out,
  output logic                 fwd_vld_out,
  input  logic                 fwd_rdy_in,
  output logic [ADDR_BITS-1:0] prx_addr_out,
  output logic [31:0]          prx_wdata_out,
  output logic                 prx_en_out,
  output logic                 cfg_wr_evt_out,
  output logic                 cfg_err_evt_out
);

  logic released_p0;
  logic slot_free_p0;
  logic accept_p0;
  logic cfg_hit_p0;
  logic wr_p0;
  logic err_p0;
  logic fwd_load_p0;
  pkt_t in_pkt_p0;

  pkt_t                 fwd_pkt_p1;
  logic                 fwd_vld_p1;
  logic                 prx_en_p1;
  logic                 wr_evt_p1;
  logic                 err_evt_p1;
  logic [ADDR_BITS-1:0] prx_addr_p1;
  logic [31:0]          prx_wdata_p1;

  // Ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) released_p0 <= 1'b0;
    else         released_p0 <= 1'b1;
  end

  // Both packet classes share one accept rule so ordering is never violated.
  assign pkt_rdy_out = released_p0 && slot_free_p0;
  assign accept_p0   = pkt_vld_in && pkt_rdy_out;
  assign cfg_hit_p0  = key_hit(pkt_key_in, CFG_KEY, CFG_MASK);
  assign wr_p0       = accept_p0 && cfg_hit_p0 && pkt_has_pld_in;
  assign err_p0      = accept_p0 && cfg_hit_p0 && !pkt_has_pld_in;
  assign fwd_load_p0 = accept_p0 && !cfg_hit_p0;

  assign in_pkt_p0 = '{key: pkt_key_in, payload: pkt_payload_in, has_pld: pkt_has_pld_in};

  pkt_fwd_reg u_fwd_reg (
    .clk    (clk),
    .resetn (resetn),
    .din    (in_pkt_p0),
    .load   (fwd_load_p0),
    .free   (slot_free_p0),
    .dout   (fwd_pkt_p1),
    .vld    (fwd_vld_p1),
    .rdy    (fwd_rdy_in)
  );

  // Stage p0 -> p1: register-write strobe and event pulses, no backpressure.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prx_en_p1  <= 1'b0;
      wr_evt_p1  <= 1'b0;
      err_evt_p1 <= 1'b0;
    end else begin
      prx_en_p1  <= wr_p0;
      wr_evt_p1  <= wr_p0;
      err_evt_p1 <= err_p0;
    end
  end

  // Address and data hold their last written values between strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prx_addr_p1  <= '0;
      prx_wdata_p1 <= '0;
    end else if (wr_p0) begin
      prx_addr_p1  <= pkt_key_in[ADDR_BITS-1:0];
      prx_wdata_p1 <= pkt_payload_in;
    end
  end

  assign fwd_key_out     = fwd_pkt_p1.key;
  assign fwd_payload_out = fwd_pkt_p1.payload;
  assign fwd_has_pld_out = fwd_pkt_p1.has_pld;
  assign fwd_vld_out     = fwd_vld_p1;

  assign prx_en_out      = prx_en_p1;
  assign prx_addr_out    = prx_addr_p1;
  assign prx_wdata_out   = prx_wdata_p1;
  assign cfg_wr_evt_out  = wr_evt_p1;
  assign cfg_err_evt_out = err_evt_p1;

endmodule

// File: tb/tb_hssl_cfg_pkt_rx.sv
// Scoreboard bench for hssl_cfg_pkt_rx: directed cases followed by a random stream.
module tb_hssl_cfg_pkt_rx;

  localparam logic [31:0] KEY_REF  = 32'hffff_fe00;
  localparam logic [31:0] MASK_REF = 32'hffff_ff00;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pkt_key_in = '0;
  logic [31:0] pkt_payload_in = '0;
  logic        pkt_has_pld_in = 1'b0;
  logic        pkt_vld_in = 1'b0;
  logic        pkt_rdy_out;
  logic [31:0] fwd_key_out;
  logic [31:0] fwd_payload_out;
  logic        fwd_has_pld_out;
  logic        fwd_vld_out;
  logic        fwd_rdy_in = 1'b0;
  logic [7:0]  prx_addr_out;
  logic [31:0] prx_wdata_out;
  logic        prx_en_out;
  logic        cfg_wr_evt_out;
  logic        cfg_err_evt_out;

  always #5 clk = ~clk;

  hssl_cfg_pkt_rx dut (
    .clk             (clk),
    .resetn          (resetn),
    .pkt_key_in      (pkt_key_in),
    .pkt_payload_in  (pkt_payload_in),
    .pkt_has_pld_in  (pkt_has_pld_in),
    .pkt_vld_in      (pkt_vld_in),
    .pkt_rdy_out     (pkt_rdy_out),
    .fwd_key_out     (fwd_key_out),
    .fwd_payload_out (fwd_payload_out),
    .fwd_has_pld_out (fwd_has_pld_out),
    .fwd_vld_out     (fwd_vld_out),
    .fwd_rdy_in      (fwd_rdy_in),
    .prx_addr_out    (prx_addr_out),
    .prx_wdata_out   (prx_wdata_out),
    .prx_en_out      (prx_en_out),
    .cfg_wr_evt_out  (cfg_wr_evt_out),
    .cfg_err_evt_out (cfg_err_evt_out)
  );

  typedef struct {
    logic [31:0] key;
    logic [31:0] pld;
    logic        has;
  } fwd_t;

  typedef struct {
    int          stamp;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  fwd_t fwd_q[$];
  wr_t  wr_q[$];
  int   err_q[$];

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          occ = 0;
  bit          released = 0;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush_model();
    occ = 0;
    released = 0;
    fwd_q.delete();
    wr_q.delete();
    err_q.delete();
    last_addr = '0;
    last_data = '0;
  endtask

  // One clock of stimulus; the model decides acceptance from its own view of
  // forward-slot occupancy and records what the DUT must produce.
  task automatic step(input bit rst_hi, input bit vld, input logic [31:0] key,
                      input logic [31:0] pld, input bit has, input bit frdy, output bit acc);
    bit   rdy_m;
    bit   hit;
    wr_t  w;
    fwd_t f;
    @(posedge clk);
    #1;
    resetn         = rst_hi;
    pkt_vld_in     = vld;
    pkt_key_in     = key;
    pkt_payload_in = pld;
    pkt_has_pld_in = has;
    fwd_rdy_in     = frdy;
    #7;
    acc = 0;
    if (!resetn) begin
      chk("rdy_in_reset", pkt_rdy_out, 0);
      flush_model();
    end else begin
      rdy_m = released && (!occ || frdy);
      chk("pkt_rdy", pkt_rdy_out, rdy_m);
      chk("fwd_vld_occupancy", fwd_vld_out, occ);
      acc = vld && rdy_m;
      hit = ((key & MASK_REF) == (KEY_REF & MASK_REF));
      if (acc && hit && has) begin
        w.stamp = cyc + 1;
        w.addr  = key[7:0];
        w.data  = pld;
        wr_q.push_back(w);
      end
      if (acc && hit && !has) err_q.push_back(cyc + 1);
      if (occ && frdy) occ = 0;
      if (acc && !hit) begin
        occ   = 1;
        f.key = key;
        f.pld = pld;
        f.has = has;
        fwd_q.push_back(f);
      end
      released = 1;
    end
  endtask

  task automatic send(input logic [31:0] key, input logic [31:0] pld, input bit has, input bit frdy);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(1, 1, key, pld, has, frdy, acc);
      tries++;
    end
    chk("send_accepted", acc, 1);
  endtask

  task automatic idle(input int n, input bit frdy);
    bit acc;
    for (int i = 0; i < n; i++) step(1, 0, $urandom, $urandom, 1'b0, frdy, acc);
  endtask

  // Pull reset between edges and check the outputs fall without a clock.
  task automatic mid_reset(input bit exp_fwd, input bit exp_en);
    bit acc;
    @(posedge clk);
    #2;
    chk("pre_reset_fwd_vld", fwd_vld_out, exp_fwd);
    chk("pre_reset_prx_en", prx_en_out, exp_en);
    resetn = 1'b0;
    #1;
    chk("async_fwd_vld", fwd_vld_out, 0);
    chk("async_prx_en", prx_en_out, 0);
    chk("async_wr_evt", cfg_wr_evt_out, 0);
    chk("async_rdy", pkt_rdy_out, 0);
    chk("async_fwd_key", fwd_key_out, 0);
    chk("async_prx_addr", prx_addr_out, 0);
    flush_model();
    step(0, 0, '0, '0, 1'b0, 1'b1, acc);
    step(1, 0, '0, '0, 1'b0, 1'b1, acc);
  endtask

  always @(negedge clk) begin : monitor
    bit   exp_en;
    bit   exp_err;
    fwd_t f;
    wr_t  w;
    if (resetn) begin
      while (wr_q.size() > 0 && wr_q[0].stamp < cyc) begin
        chk("wr_stamp", wr_q[0].stamp, cyc);
        void'(wr_q.pop_front());
      end
      while (err_q.size() > 0 && err_q[0] < cyc) begin
        chk("err_stamp", err_q[0], cyc);
        void'(err_q.pop_front());
      end
      exp_en  = (wr_q.size() > 0) && (wr_q[0].stamp == cyc);
      exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
      chk("prx_en", prx_en_out, exp_en);
      chk("cfg_wr_evt", cfg_wr_evt_out, exp_en);
      chk("cfg_err_evt", cfg_err_evt_out, exp_err);
      if (exp_en) begin
        w = wr_q.pop_front();
        last_addr = w.addr;
        last_data = w.data;
      end
      if (exp_err) void'(err_q.pop_front());
      chk("prx_addr", prx_addr_out, last_addr);
      chk("prx_wdata", prx_wdata_out, last_data);
      if (fwd_vld_out) begin
        if (fwd_q.size() == 0) begin
          chk("fwd_unexpected", fwd_q.size(), 1);
        end else begin
          f = fwd_q[0];
          chk("fwd_key", fwd_key_out, f.key);
          chk("fwd_payload", fwd_payload_out, f.pld);
          chk("fwd_has_pld", fwd_has_pld_out, f.has);
          if (fwd_rdy_in) void'(fwd_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit          acc;
    bit          hold;
    logic [31:0] k;
    logic [31:0] p;
    bit          h;
    bit          v;

    for (int i = 0; i < 3; i++) step(0, 1, 32'hffff_fe31, 32'h40, 1'b1, 1'b1, acc);
    chk("reset_fwd_vld", fwd_vld_out, 0);
    chk("reset_prx_en", prx_en_out, 0);
    chk("reset_wr_evt", cfg_wr_evt_out, 0);
    chk("reset_err_evt", cfg_err_evt_out, 0);
    chk("reset_fwd_key", fwd_key_out, 0);
    chk("reset_fwd_payload", fwd_payload_out, 0);
    chk("reset_fwd_has", fwd_has_pld_out, 0);
    chk("reset_prx_addr", prx_addr_out, 0);
    chk("reset_prx_wdata", prx_wdata_out, 0);

    step(1, 0, '0, '0, 1'b0, 1'b1, acc);
    send(32'hffff_fe31, 32'h0000_0040, 1'b1, 1'b1);
    idle(2, 1'b1);

    send(32'h1234_5678, 32'hcafe_f00d, 1'b1, 1'b1);
    idle(2, 1'b1);

    send(32'h0000_0101, 32'h1111_1111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h0000_0202, 32'h2222_2222, 1'b0, 1'b0, acc);
    send(32'h0000_0202, 32'h2222_2222, 1'b0, 1'b1);
    send(32'h0000_0303, 32'h3333_3333, 1'b1, 1'b1);
    idle(3, 1'b1);

    send(32'hffff_fe05, 32'hdead_beef, 1'b0, 1'b1);
    idle(2, 1'b1);

    send(32'h0abc_0001, 32'h0000_0001, 1'b1, 1'b1);
    send(32'hffff_fe00, 32'h0000_00a0, 1'b1, 1'b1);
    send(32'hffff_fe41, 32'h0000_00b1, 1'b1, 1'b1);
    send(32'h0abc_0002, 32'h0000_0002, 1'b0, 1'b1);
    idle(3, 1'b1);

    send(32'h5555_0000, 32'h5a5a_5a5a, 1'b1, 1'b0);
    mid_reset(1'b1, 1'b0);
    send(32'hffff_fe7f, 32'h0bad_cafe, 1'b1, 1'b1);
    mid_reset(1'b0, 1'b1);
    send(32'hffff_fe12, 32'h0000_1234, 1'b1, 1'b1);
    send(32'h7777_0012, 32'h0000_5678, 1'b1, 1'b1);
    idle(3, 1'b1);

    hold = 0;
    k = '0;
    p = '0;
    h = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        case ($urandom_range(0, 5))
          0, 1:    k = KEY_REF | 32'($urandom_range(0, 255));
          2:       k = (KEY_REF | 32'($urandom_range(0, 255))) ^ (32'h1 << $urandom_range(8, 31));
          default: k = $urandom;
        endcase
        p = $urandom;
        h = ($urandom_range(0, 4) != 0);
        v = ($urandom_range(0, 9) < 7);
      end
      step(1, v, k, p, h, ($urandom_range(0, 9) < 6), acc);
      hold = v && !acc;
    end

    idle(6, 1'b1);
    chk("fwd_queue_drained", fwd_q.size(), 0);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/hssl_cfg_pkt_rx.md
Name: hssl_cfg_pkt_rx

Overview:
- Sits directly upstream of the register bank's packet receiver interface.
- Inspects every multicast packet arriving from the HSSL receive path.
  - Configuration packets (key matches a programmable-at-elaboration key/mask) become single-cycle register writes.
  - All other packets are forwarded unchanged to the input router through a registered valid/ready stage.
- Also produces event pulses for the diagnostic packet counters.

Parameters:
- CFG_KEY, 32'hffff_fe00: routing key that identifies configuration packets.
- CFG_MASK, 32'hffff_ff00: mask applied to the incoming key before comparison with CFG_KEY.
- ADDR_BITS, 8: width of the register address taken from key[ADDR_BITS-1:0].

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- pkt_key_in  in  32  incoming packet routing key.
- pkt_payload_in  in  32  incoming payload; valid only when pkt_has_pld_in=1.
- pkt_has_pld_in  in  1  incoming packet carries a payload.
- pkt_vld_in  in  1  incoming packet valid.
- pkt_rdy_out  out  1  block can accept a packet.
- fwd_key_out  out  32  forwarded key.
- fwd_payload_out  out  32  forwarded payload.
- fwd_has_pld_out  out  1  forwarded payload flag.
- fwd_vld_out  out  1  forwarded packet valid.
- fwd_rdy_in  in  1  downstream (input router) ready.
- prx_addr_out  out  8  register word address (section in [6:4], number in [3:0]).
- prx_wdata_out  out  32  register write data.
- prx_en_out  out  1  register write strobe, one cycle.
- cfg_wr_evt_out  out  1  pulse: configuration write performed.
- cfg_err_evt_out  out  1  pulse: configuration packet without payload, dropped.

Behaviour:
- Reset values:
  - pkt_rdy_out: 0 while resetn=0; 1 from the first clk edge after release.
  - fwd_vld_out, prx_en_out, cfg_wr_evt_out, cfg_err_evt_out: all 0.
  - fwd_key_out, fwd_payload_out, prx_wdata_out: 0.
  - fwd_has_pld_out: 0; prx_addr_out: 0.
- Accept rule:
  - Accept occurs when pkt_vld_in && pkt_rdy_out.
  - pkt_rdy_out = !fwd_vld_out || fwd_rdy_in, registered-free combinational term gated by a reset-released flag.
  - Packets of either class are accepted only under this rule, so packet order is preserved.
- Classification: cfg_hit = ((pkt_key_in & CFG_MASK) == (CFG_KEY & CFG_MASK)), evaluated on the accept cycle.
- Config hit with payload:
  - Next cycle: prx_en_out=1, prx_addr_out=pkt_key_in[7:0], prx_wdata_out=pkt_payload_in, cfg_wr_evt_out=1.
  - Latency is one cycle. No backpressure: the register bank gives packet writes priority.
- Config hit without payload:
  - Next cycle: cfg_err_evt_out=1, prx_en_out stays 0.
  - The packet is consumed and not forwarded.
- Non-config packet:
  - Loaded into the forward register next cycle; fwd_vld_out=1.
  - Key, payload and flag are held stable while fwd_vld_out && !fwd_rdy_in.
- Forward register update on each clk:
  - If an accepted non-config packet arrives, load it.
  - Else if fwd_rdy_in, clear fwd_vld_out.
  - Simultaneous drain and load in one cycle is required: throughput of 1 packet/cycle.
- Back-to-back config packets: one write per cycle, no gaps.
- Config packet arriving while fwd stalled: not accepted until the stall clears (order rule).
- prx_en_out, cfg_wr_evt_out and cfg_err_evt_out are single-cycle pulses, deasserted unless re-triggered the next cycle.
- Reset mid-operation: the in-flight forwarded packet and any pending write are discarded; outputs return to reset values immediately (asynchronous).
- prx_wdata_out/prx_addr_out retain their last values when prx_en_out=0.

Decomposition:
- Shared package hssl_pkg:
  - CFG_KEY_DEF and CFG_MASK_DEF.
  - Section-field constants (SEC_BITS=3, REG_BITS=4, PRX_SEC_LSB=4) shared with the register bank.
  - Packet struct typedef (key, payload, has_pld).
- One sub-module, pkt_fwd_reg: a single-entry valid/ready pipeline register reused elsewhere on the HSSL datapath.
- Classification and the config write logic stay in the top.

Test Plan:
- Reset release, then a packet with key=32'hffff_fe31, payload=32'h0000_0040 -> one cycle later prx_en_out=1, prx_addr_out=8'h31, prx_wdata_out=32'h40, cfg_wr_evt_out=1. fwd_vld_out stays 0.
- Key=32'h1234_5678, payload=32'hcafe_f00d, fwd_rdy_in=1 -> fwd_vld_out=1 next cycle with identical key/payload/flag. prx_en_out stays 0.
- fwd_rdy_in=0 with 3 data packets offered -> the first is held stable and pkt_rdy_out=0. Raise fwd_rdy_in -> packets emerge in order at 1/cycle with no loss or duplication.
- Key=32'hffff_fe05 with pkt_has_pld_in=0 -> cfg_err_evt_out pulses once. No prx_en_out, nothing forwarded.
- Interleaved stream (data, cfg 0x00, cfg 0x41, data) at full rate -> two consecutive single-cycle writes, two forwarded packets in order.
- Assert resetn=0 while fwd_vld_out=1 and prx_en_out=1 -> both drop to 0 without a clock edge. After release, the first accepted packet behaves normally.
